// File: rtl/rtc_tick_gen.sv
// RTC square-wave and tick generator with a handshaked half-period divisor.
// Define RTC_TICK_GEN_FRAC_EN to stretch low phases by a fractional accumulator.
module rtc_tick_gen #(
   parameter int DIV_WIDTH         = 16,
   parameter int RESET_HALF_PERIOD = 763
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 testmode_i,
   input  logic                 halt_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [DIV_WIDTH-1:0] cfg_half_period_i,
   input  logic [7:0]           cfg_frac_i,
   output logic                 rtc_o,
   output logic                 tick_o,
   output logic [DIV_WIDTH-1:0] half_period_o
);

   localparam logic [DIV_WIDTH-1:0] RST_HP = DIV_WIDTH'(RESET_HALF_PERIOD);
   localparam logic [DIV_WIDTH:0]   ONE_W  = (DIV_WIDTH+1)'(1);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 rtc_q, rtc_d;
   logic                 tick_q, tick_d;
   logic                 pend_q, pend_d;
   logic [DIV_WIDTH-1:0] pend_hp_q, pend_hp_d;
   logic [DIV_WIDTH-1:0] hp_q, hp_d;

   logic [DIV_WIDTH-1:0] hp_eff;
   logic [DIV_WIDTH:0]   limit;
   logic                 ext;
   logic                 term;
   logic                 full_end;
   logic                 xfer;

`ifdef RTC_TICK_GEN_FRAC_EN
   logic [7:0] pend_frac_q, pend_frac_d;
   logic [7:0] frac_q, frac_d;
   logic [7:0] acc_q, acc_d;
   logic       ext_q, ext_d;

   assign ext = ext_q;
`else
   logic unused_frac;

   assign unused_frac = ^cfg_frac_i;
   assign ext         = 1'b0;
`endif

   always_comb begin
      hp_eff = hp_q;
      if (testmode_i || (hp_q == '0)) begin
         hp_eff = DIV_WIDTH'(1);
      end
      // One extra count stretches a low phase on accumulator carry.
      limit    = {1'b0, hp_eff} + {{DIV_WIDTH{1'b0}}, ext};
      term     = !halt_i && ({1'b0, cnt_q} == (limit - ONE_W));
      full_end = term && rtc_q;
      xfer     = cfg_valid_i && !pend_q;
   end

   always_comb begin
      cnt_d     = cnt_q;
      rtc_d     = rtc_q;
      tick_d    = 1'b0;
      pend_d    = pend_q;
      pend_hp_d = pend_hp_q;
      hp_d      = hp_q;
`ifdef RTC_TICK_GEN_FRAC_EN
      pend_frac_d = pend_frac_q;
      frac_d      = frac_q;
      acc_d       = acc_q;
      ext_d       = ext_q;
`endif
      if (!halt_i) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (term) begin
         cnt_d  = '0;
         rtc_d  = !rtc_q;
         tick_d = !rtc_q;
      end
      if (xfer) begin
         pend_d    = 1'b1;
         pend_hp_d = cfg_half_period_i;
`ifdef RTC_TICK_GEN_FRAC_EN
         pend_frac_d = cfg_frac_i;
`endif
      end
      if (full_end && pend_q) begin
         pend_d = 1'b0;
         hp_d   = pend_hp_q;
`ifdef RTC_TICK_GEN_FRAC_EN
         frac_d = pend_frac_q;
`endif
      end
`ifdef RTC_TICK_GEN_FRAC_EN
      if (full_end) begin
         {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_q};
      end else if (term) begin
         ext_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         rtc_q     <= 1'b0;
         tick_q    <= 1'b0;
         pend_q    <= 1'b0;
         pend_hp_q <= '0;
         hp_q      <= RST_HP;
      end else begin
         cnt_q     <= cnt_d;
         rtc_q     <= rtc_d;
         tick_q    <= tick_d;
         pend_q    <= pend_d;
         pend_hp_q <= pend_hp_d;
         hp_q      <= hp_d;
      end
   end

`ifdef RTC_TICK_GEN_FRAC_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_frac_q <= '0;
         frac_q      <= '0;
         acc_q       <= '0;
         ext_q       <= 1'b0;
      end else begin
         pend_frac_q <= pend_frac_d;
         frac_q      <= frac_d;
         acc_q       <= acc_d;
         ext_q       <= ext_d;
      end
   end
`endif

   assign cfg_ready_o   = !pend_q;
   assign rtc_o         = rtc_q;
   assign tick_o        = tick_q;
   assign half_period_o = hp_q;

endmodule
